// File: rtl/parity_scan_pkg.sv
`default_nettype none
// ============================================================================
// parity_scan_pkg : shared FSM state type and reference hit function for the
//                   parity-select scanner.
// Revision 1.0
// ============================================================================
package parity_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width-generic hit evaluation: operands arrive sign-extended to 32 bits and
  // the sum is truncated to w bits before its parity is taken.
  function automatic logic sel_hit(input logic signed [31:0] idx,
                                   input logic signed [31:0] sample,
                                   input int unsigned         w);
    logic [31:0] mask;
    logic [31:0] sum;
    logic        p;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    sum  = (idx + sample) & mask;
    p    = ^sum;
    return p ? (idx != 0) : (sample != 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_sel_cell.sv
`default_nettype none
// ============================================================================
// parity_sel_cell : combinational sum / parity / select / nonzero evaluation
//                   for one (idx, sample) pair.
// Revision 1.0
// ============================================================================
module parity_sel_cell #(
  parameter int DATA_W = 6,
  parameter int IDX_W  = 7
) (
  input  logic signed [IDX_W-1:0]  idx,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     hit
);

  localparam int c_w = (IDX_W > DATA_W) ? IDX_W : DATA_W;

  logic signed [c_w-1:0] w_idx_ext;
  logic signed [c_w-1:0] w_sample_ext;
  logic signed [c_w-1:0] w_sum;
  logic signed [c_w-1:0] w_sel;
  logic                  w_parity;

  assign w_idx_ext    = c_w'(idx);
  assign w_sample_ext = c_w'(sample);
  // Carry out of the top bit is dropped on purpose: wrap-around is part of the model.
  assign w_sum        = w_idx_ext + w_sample_ext;
  assign w_parity     = ^w_sum;
  assign w_sel        = w_parity ? w_idx_ext : w_sample_ext;
  assign hit          = |w_sel;

endmodule
`default_nettype wire

// File: rtl/parity_scan_engine.sv
`default_nettype none
// ============================================================================
// parity_scan_engine : scans each accepted sample over SCAN_LEN loop indices,
//                      one per clock, flagging and counting select hits.
// Revision 1.0
// ============================================================================
module parity_scan_engine
  import parity_scan_pkg::*;
#(
  parameter int                DATA_W   = 6,
  parameter int                IDX_W    = 7,
  parameter int                SCAN_LEN = 4,
  parameter int                FLAG_W   = 2,
  parameter logic [FLAG_W-1:0] FLAG_VAL = 2'b01,
  parameter int                CNT_W    = $clog2(SCAN_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     sticky,
  output logic [FLAG_W-1:0]        y,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic                     done
);

  localparam logic signed [IDX_W-1:0] c_last_idx = IDX_W'(SCAN_LEN - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [IDX_W-1:0]   r_idx;
  logic signed [DATA_W-1:0]  r_sample;
  logic [CNT_W-1:0]          r_run_cnt;
  logic [FLAG_W-1:0]         r_y;
  logic [CNT_W-1:0]          r_hit_cnt;
  logic                      w_hit;
  logic                      w_last;
  logic                      w_accept;

  parity_sel_cell #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cell (
    .idx    (r_idx),
    .sample (r_sample),
    .hit    (w_hit)
  );

  assign w_last   = (r_idx == c_last_idx);
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_sample  <= '0;
      r_run_cnt <= '0;
      r_y       <= '0;
      r_hit_cnt <= '0;
    end else if (w_accept) begin
      r_sample  <= in_data;
      r_idx     <= '0;
      r_run_cnt <= '0;
      if (!sticky) r_y <= '0;
    end else if (r_state == SCAN) begin
      if (w_hit) begin
        r_y <= FLAG_VAL;
        if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 1'b1;
      end
      // Index stops at the last position; termination never relies on wrap.
      if (!w_last) r_idx <= r_idx + 1'b1;
    end else if (r_state == DONE) begin
      r_hit_cnt <= r_run_cnt;
    end
  end

  assign y       = r_y;
  assign hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_parity_scan_engine.sv
`default_nettype none
// ============================================================================
// tb_parity_scan_engine : directed self-checking bench for parity_scan_engine
//                         (SCAN_LEN=4 instance a, SCAN_LEN=1 instance b).
// Revision 1.0
// ============================================================================
module tb_parity_scan_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, a_sticky, a_done;
  logic [5:0] a_data;
  logic [1:0] a_y;
  logic [2:0] a_cnt;
  logic       b_valid, b_ready, b_sticky, b_done;
  logic [5:0] b_data;
  logic [1:0] b_y;
  logic [0:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_scan_engine #(.SCAN_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .sticky(a_sticky), .y(a_y), .hit_cnt(a_cnt), .done(a_done)
  );

  parity_scan_engine #(.SCAN_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .sticky(b_sticky), .y(b_y), .hit_cnt(b_cnt), .done(b_done)
  );

  // Stimulus drivers: caller sits on a falling edge; observations come back out.
  task automatic scan_a(input logic [5:0] d, input logic st, output logic rdy0,
                        output int dcyc, output logic [2:0] cnt, output logic [1:0] yv,
                        output logic rdy_end);
    rdy0 = a_ready; a_data = d; a_sticky = st; a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); a_valid = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (a_done) begin dcyc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rdy_end = a_ready; cnt = a_cnt; yv = a_y;
  endtask

  task automatic scan_b(input logic [5:0] d, input logic st, output int dcyc,
                        output logic [0:0] cnt, output logic [1:0] yv);
    b_data = d; b_sticky = st; b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); b_valid = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (b_done) begin dcyc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cnt = b_cnt; yv = b_y;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_y !== 2'b00 || a_cnt !== 3'd0 || a_done !== 1'b0)
      begin failures++; $display("FAIL reset_a: y=%b cnt=%0d done=%b expected 00/0/0", a_y, a_cnt, a_done); end
    checks++; if (a_ready !== 1'b1)
      begin failures++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
    checks++; if (b_y !== 2'b00 || b_cnt !== 1'b0 || b_done !== 1'b0)
      begin failures++; $display("FAIL reset_b: y=%b cnt=%0d done=%b expected 00/0/0", b_y, b_cnt, b_done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_scan_basic();
    logic [5:0] d   [4] = '{6'h00, 6'h3F, 6'h3D, 6'h3C};
    logic [2:0] exp [4] = '{3'd2,  3'd3,  3'd4,  3'd3};
    logic rdy0, rdy_end; int dcyc; logic [2:0] cnt; logic [1:0] yv;
    for (int i = 0; i < 4; i++) begin
      scan_a(d[i], 1'b0, rdy0, dcyc, cnt, yv, rdy_end);
      checks++; if (dcyc != 5)
        begin failures++; $display("FAIL done_cycle[%0h]: got %0d expected 5", d[i], dcyc); end
      checks++; if (cnt !== exp[i])
        begin failures++; $display("FAIL hit_cnt[%0h]: got %0d expected %0d", d[i], cnt, exp[i]); end
      checks++; if (yv !== 2'b01)
        begin failures++; $display("FAIL y[%0h]: got %b expected 01", d[i], yv); end
      checks++; if (rdy0 !== 1'b1 || rdy_end !== 1'b1)
        begin failures++; $display("FAIL ready_edges[%0h]: got %b/%b expected 1/1", d[i], rdy0, rdy_end); end
    end
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++; if (a_cnt !== 3'd3 || a_y !== 2'b01 || a_done !== 1'b0)
      begin failures++; $display("FAIL hold: cnt=%0d y=%b done=%b expected 3/01/0", a_cnt, a_y, a_done); end
  endtask

  task automatic test_y_early();
    do_reset();
    a_data = 6'h00; a_sticky = 1'b0; a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_y !== 2'b00)
      begin failures++; $display("FAIL y_cycle2: got %b expected 00", a_y); end
    @(negedge clk);
    checks++; if (a_y !== 2'b01 || a_done !== 1'b0)
      begin failures++; $display("FAIL y_cycle3: y=%b done=%b expected 01/0", a_y, a_done); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_valid_held();
    int dcyc = -1;
    a_data = 6'h00; a_sticky = 1'b0; a_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (a_done && dcyc < 0) dcyc = c;
      if (c < 6) begin
        checks++; if (a_ready !== 1'b0)
          begin failures++; $display("FAIL held_ready[c%0d]: got %b expected 0", c, a_ready); end
      end
      a_data = 6'h05;
    end
    checks++; if (a_ready !== 1'b1)
      begin failures++; $display("FAIL held_ready[c6]: got %b expected 1", a_ready); end
    a_valid = 1'b0;
    checks++; if (a_cnt !== 3'd2 || dcyc != 5)
      begin failures++; $display("FAIL held_first_only: cnt=%0d done_cycle=%0d expected 2/5", a_cnt, dcyc); end
  endtask

  task automatic test_reset_mid();
    logic rdy0, rdy_end; int dcyc; logic [2:0] cnt; logic [1:0] yv;
    @(negedge clk); a_data = 6'h05; a_sticky = 1'b0; a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); a_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (a_y !== 2'b00 || a_cnt !== 3'd0 || a_done !== 1'b0 || a_ready !== 1'b1)
      begin failures++; $display("FAIL mid_reset: y=%b cnt=%0d done=%b rdy=%b expected 00/0/0/1", a_y, a_cnt, a_done, a_ready); end
    @(negedge clk); rst_n = 1'b1;
    scan_a(6'h3F, 1'b0, rdy0, dcyc, cnt, yv, rdy_end);
    checks++; if (rdy0 !== 1'b1 || dcyc != 5 || cnt !== 3'd3)
      begin failures++; $display("FAIL after_reset: rdy=%b done_cycle=%0d cnt=%0d expected 1/5/3", rdy0, dcyc, cnt); end
  endtask

  task automatic test_scan_len1();
    int dcyc; logic [0:0] cnt; logic [1:0] yv;
    do_reset();
    scan_b(6'h00, 1'b0, dcyc, cnt, yv);
    checks++; if (dcyc != 2)
      begin failures++; $display("FAIL len1_done_cycle: got %0d expected 2", dcyc); end
    checks++; if (cnt !== 1'b0 || yv !== 2'b00)
      begin failures++; $display("FAIL len1_zero: cnt=%0d y=%b expected 0/00", cnt, yv); end
  endtask

  task automatic test_sticky();
    int dcyc; logic [0:0] cnt; logic [1:0] yv;
    scan_b(6'h05, 1'b0, dcyc, cnt, yv);
    checks++; if (cnt !== 1'b1 || yv !== 2'b01)
      begin failures++; $display("FAIL len1_hit: cnt=%0d y=%b expected 1/01", cnt, yv); end
    scan_b(6'h00, 1'b0, dcyc, cnt, yv);
    checks++; if (cnt !== 1'b0 || yv !== 2'b00)
      begin failures++; $display("FAIL nonsticky_clear: cnt=%0d y=%b expected 0/00", cnt, yv); end
    scan_b(6'h05, 1'b0, dcyc, cnt, yv);
    scan_b(6'h00, 1'b1, dcyc, cnt, yv);
    checks++; if (cnt !== 1'b0 || yv !== 2'b01)
      begin failures++; $display("FAIL sticky_keep: cnt=%0d y=%b expected 0/01", cnt, yv); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_sticky = 1'b0;
    b_valid = 1'b0; b_data = '0; b_sticky = 1'b0;
    test_reset();
    test_scan_basic();
    test_hold();
    test_y_early();
    test_valid_held();
    test_reset_mid();
    test_scan_len1();
    test_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
